// File: rtl/fp_flag_monitor_if.sv
// fp_flag_monitor_if: operand issue and DUT result/flag bundle observed by the monitor
interface fp_flag_monitor_if;
   logic        en;
   logic        sel;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] R;
   logic        io_flag;
   logic        dz_flag;
   logic        of_flag;
   logic        uf_flag;
   logic        i_flag;
   modport master (output en, sel, a, b, R, io_flag, dz_flag, of_flag, uf_flag, i_flag);
   modport slave  (input  en, sel, a, b, R, io_flag, dz_flag, of_flag, uf_flag, i_flag);
endinterface

// File: rtl/fp_flag_monitor.sv
// fp_flag_monitor: checks FP mul/div results and flags against operand-derived expectations; FPMON_SNAPSHOT_EN adds first-failure capture
module fp_flag_monitor #(
   parameter int R_DLY = 23,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               arst,
   fp_flag_monitor_if.slave   bus,
   input  logic               clr,
   output logic               err_pulse,
   output logic [4:0]         err_sticky,
   output logic [5*CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0]   op_cnt
`ifdef FPMON_SNAPSHOT_EN
   ,
   output logic [31:0]        snap_a,
   output logic [31:0]        snap_b,
   output logic [31:0]        snap_R,
   output logic [2:0]         snap_id
`endif
);
   localparam int L = R_DLY - 1;
   localparam logic [30:0] INF = 31'h7F800000;

   logic a_nan, b_nan, a_zero, b_zero, a_fin, b_fin;
   logic [8:0] exp_sum;
   logic [4:0] chk_en;
   logic [4:0] fail;
   logic r_inf;
   logic unused_flags;

   logic       v_q   [R_DLY];
   logic [4:0] en_q  [R_DLY];
   logic       sgn_q [R_DLY];
`ifdef FPMON_SNAPSHOT_EN
   logic [63:0] ops_q [R_DLY];
`endif

   assign a_fin   = ~&bus.a[30:23];
   assign b_fin   = ~&bus.b[30:23];
   assign a_nan   = ~a_fin & |bus.a[22:0];
   assign b_nan   = ~b_fin & |bus.b[22:0];
   assign a_zero  = ~|bus.a[30:0];
   assign b_zero  = ~|bus.b[30:0];
   assign exp_sum = {1'b0, bus.a[30:23]} + {1'b0, bus.b[30:23]};
   assign chk_en  = {~bus.sel & a_fin & b_fin & ~a_zero & ~b_zero & (exp_sum >= 9'd382),
                     ~a_nan & ~b_nan,
                     a_nan | b_nan,
                     bus.sel & a_zero & ~b_zero & ~b_nan,
                     bus.sel & b_zero & ~a_zero & ~a_nan};
   assign r_inf   = bus.R[30:0] == INF;
   assign fail    = {5{v_q[L]}} & en_q[L] & {~(bus.of_flag & r_inf),
                                             bus.R[31] != sgn_q[L],
                                             ~bus.io_flag,
                                             |bus.R[30:0],
                                             ~(bus.dz_flag & r_inf)};
   assign unused_flags = bus.uf_flag ^ bus.i_flag;

   // delay line carrying per-op check enables and expected sign to retirement
   always_ff @(posedge clk) begin
      if (arst) begin
         for (int i = 0; i < R_DLY; i++) v_q[i] <= 1'b0;
      end else begin
         v_q[0]   <= bus.en;
         en_q[0]  <= chk_en;
         sgn_q[0] <= bus.a[31] ^ bus.b[31];
`ifdef FPMON_SNAPSHOT_EN
         ops_q[0] <= {bus.a, bus.b};
`endif
         for (int i = 1; i < R_DLY; i++) begin
            v_q[i]   <= v_q[i-1];
            en_q[i]  <= en_q[i-1];
            sgn_q[i] <= sgn_q[i-1];
`ifdef FPMON_SNAPSHOT_EN
            ops_q[i] <= ops_q[i-1];
`endif
         end
      end
   end

   // retirement bookkeeping: saturating counters, sticky bits, error pulse; clr beats retiring failures
   always_ff @(posedge clk) begin
      if (arst || clr) begin
         err_pulse  <= 1'b0;
         err_sticky <= '0;
         err_cnt    <= '0;
         op_cnt     <= '0;
`ifdef FPMON_SNAPSHOT_EN
         snap_a     <= '0;
         snap_b     <= '0;
         snap_R     <= '0;
         snap_id    <= '0;
`endif
      end else begin
         err_pulse  <= |fail;
         err_sticky <= err_sticky | fail;
         if (v_q[L] && !(&op_cnt)) op_cnt <= op_cnt + CNT_W'(1);
         for (int k = 0; k < 5; k++)
            if (fail[k] && !(&err_cnt[k*CNT_W +: CNT_W]))
               err_cnt[k*CNT_W +: CNT_W] <= err_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
`ifdef FPMON_SNAPSHOT_EN
         if (|fail && err_sticky == 5'd0) begin
            snap_a  <= ops_q[L][63:32];
            snap_b  <= ops_q[L][31:0];
            snap_R  <= bus.R;
            snap_id <= fail[0] ? 3'd0 : fail[1] ? 3'd1 : fail[2] ? 3'd2 : fail[3] ? 3'd3 : 3'd4;
         end
`endif
      end
   end
endmodule

// File: tb/tb_fp_flag_monitor.sv
// tb_fp_flag_monitor: directed and random checks of fp_flag_monitor against a queue-based reference model
module tb_fp_flag_monitor;
   localparam int R_DLY = 23;
   localparam int CNT_W = 4;
   localparam int SAT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic arst, clr;
   logic err_pulse;
   logic [4:0] err_sticky;
   logic [5*CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] op_cnt;
`ifdef FPMON_SNAPSHOT_EN
   logic [31:0] snap_a, snap_b, snap_R;
   logic [2:0] snap_id;
`endif

   fp_flag_monitor_if bus();

   fp_flag_monitor #(.R_DLY(R_DLY), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst(arst), .bus(bus), .clr(clr),
      .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt), .op_cnt(op_cnt)
`ifdef FPMON_SNAPSHOT_EN
      , .snap_a(snap_a), .snap_b(snap_b), .snap_R(snap_R), .snap_id(snap_id)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
      int          rc;
   } op_t;

   op_t q[$];
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   logic m_pulse = 1'b0;
   logic [4:0] m_sticky = '0;
   int m_cnt[5];
   int m_op = 0;

   function automatic int expo(logic [31:0] x);
      return int'((x >> 23) & 32'hFF);
   endfunction
   function automatic bit is_nan(logic [31:0] x);
      return expo(x) == 255 && (x & 32'h7FFFFF) != 0;
   endfunction
   function automatic bit is_zero(logic [31:0] x);
      return (x & 32'h7FFFFFFF) == 0;
   endfunction
   function automatic bit is_fin(logic [31:0] x);
      return expo(x) != 255;
   endfunction

   function automatic logic [4:0] fails(op_t o, logic [31:0] r, logic io, logic dz, logic ov);
      logic [4:0] f = '0;
      bit an = is_nan(o.a);
      bit bn = is_nan(o.b);
      bit az = is_zero(o.a);
      bit bz = is_zero(o.b);
      bit rinf = (r & 32'h7FFFFFFF) == 32'h7F800000;
      if (o.sel && bz && !az && !an && !(dz && rinf)) f[0] = 1'b1;
      if (o.sel && az && !bz && !bn && (r & 32'h7FFFFFFF) != 0) f[1] = 1'b1;
      if ((an || bn) && !io) f[2] = 1'b1;
      if (!an && !bn && (r >> 31) != ((o.a >> 31) ^ (o.b >> 31))) f[3] = 1'b1;
      if (!o.sel && is_fin(o.a) && is_fin(o.b) && !az && !bz && expo(o.a) + expo(o.b) >= 382 && !(ov && rinf)) f[4] = 1'b1;
      return f;
   endfunction

   task automatic model_edge();
      logic [4:0] f = '0;
      bit ret = 0;
      if (arst) begin
         q.delete();
         m_pulse = 1'b0;
         m_sticky = '0;
         foreach (m_cnt[k]) m_cnt[k] = 0;
         m_op = 0;
      end else begin
         if (q.size() > 0 && q[0].rc == cyc) begin
            ret = 1;
            f = fails(q[0], bus.R, bus.io_flag, bus.dz_flag, bus.of_flag);
            void'(q.pop_front());
         end
         if (clr) begin
            m_pulse = 1'b0;
            m_sticky = '0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_op = 0;
         end else begin
            m_pulse = |f;
            m_sticky = m_sticky | f;
            if (ret && m_op < SAT) m_op++;
            for (int k = 0; k < 5; k++) if (f[k] && m_cnt[k] < SAT) m_cnt[k]++;
         end
         if (bus.en) q.push_back('{bus.a, bus.b, bus.sel, cyc + R_DLY});
      end
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic compare();
      chk("pulse", 32'(err_pulse), 32'(m_pulse));
      chk("sticky", 32'(err_sticky), 32'(m_sticky));
      for (int k = 0; k < 5; k++) chk($sformatf("cnt%0d", k), 32'(err_cnt[k*CNT_W +: CNT_W]), 32'(m_cnt[k]));
      chk("op_cnt", 32'(op_cnt), 32'(m_op));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      compare();
   endtask

   task automatic idle();
      bus.en = 1'b0; bus.sel = 1'b0; bus.a = '0; bus.b = '0;
      bus.io_flag = 1'b0; bus.dz_flag = 1'b0; bus.of_flag = 1'b0; bus.uf_flag = 1'b0; bus.i_flag = 1'b0;
      clr = 1'b0;
   endtask

   task automatic issue(logic s, logic [31:0] x, logic [31:0] y);
      bus.en = 1'b1; bus.sel = s; bus.a = x; bus.b = y;
      step();
      bus.en = 1'b0;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      arst = 1'b1;
      steps(2);
      arst = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 8))
         0: v = 32'h00000000;
         1: v = 32'h3F800000;
         2: v = 32'h7F000000;
         3: v = 32'h7FC00000;
         4: v = 32'h7F800000;
         5: v = 32'h7F800001;
         6: v = 32'h60000000;
         7: v = 32'h5F800000;
         default: v = $urandom;
      endcase
      return v ^ (32'($urandom_range(0, 1)) << 31);
   endfunction

   initial begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      idle();
      bus.R = '0;
      clr = 1'b0;
      do_reset();
      chk("rst_op", 32'(op_cnt), 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);

      issue(1'b1, 32'h3F800000, 32'h00000000);
      steps(22);
      bus.dz_flag = 1'b1; bus.R = 32'h7F800000;
      step();
      chk("dz_pass_pulse", 32'(err_pulse), 32'd0);
      chk("dz_pass_op", 32'(op_cnt), 32'd1);
      bus.dz_flag = 1'b0; bus.R = '0;
      step();

      issue(1'b1, 32'h3F800000, 32'h00000000);
      steps(22);
      bus.R = 32'h7F800000;
      step();
      chk("dz_fail_pulse", 32'(err_pulse), 32'd1);
      chk("dz_fail_sticky", 32'(err_sticky), 32'b00001);
      chk("dz_fail_cnt0", 32'(err_cnt[0 +: CNT_W]), 32'd1);
      bus.R = '0;
      step();
      chk("pulse_one_cycle", 32'(err_pulse), 32'd0);

      do_reset();
      issue(1'b0, 32'h7F000000, 32'h7F000000);
      steps(22);
      bus.of_flag = 1'b0; bus.R = 32'h7F7FFFFF;
      step();
      chk("ovf_cnt4", 32'(err_cnt[4*CNT_W +: CNT_W]), 32'd1);
      chk("ovf_sticky", 32'(err_sticky), 32'b10000);
      bus.R = '0;

      do_reset();
      issue(1'b0, 32'h7FC00000, 32'h3F800000);
      steps(4);
      issue(1'b1, 32'h3F800000, 32'h00000000);
      steps(17);
      bus.io_flag = 1'b1;
      step();
      chk("nan_op", 32'(op_cnt), 32'd1);
      chk("nan_pulse", 32'(err_pulse), 32'd0);
      bus.io_flag = 1'b0;
      arst = 1'b1;
      step();
      arst = 1'b0;
      steps(30);
      chk("flight_op", 32'(op_cnt), 32'd0);
      chk("flight_sticky", 32'(err_sticky), 32'd0);

      do_reset();
      bus.R = 32'h3F800000;
      for (int i = 0; i < 20; i++) issue(1'b0, 32'h3F800000, 32'hBF800000);
      steps(23);
      chk("sat_cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd15);
      chk("sat_op", 32'(op_cnt), 32'd15);
      chk("sat_sticky", 32'(err_sticky), 32'b01000);
      issue(1'b0, 32'h3F800000, 32'hBF800000);
      steps(22);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_cnt", 32'(err_cnt), 32'd0);
      chk("clr_op", 32'(op_cnt), 32'd0);
      chk("clr_pulse", 32'(err_pulse), 32'd0);
      chk("clr_sticky", 32'(err_sticky), 32'd0);

      for (int i = 0; i < 600; i++) begin
         arst = $urandom_range(0, 99) == 0;
         clr = $urandom_range(0, 99) < 3;
         bus.en = $urandom_range(0, 9) < 7;
         bus.sel = 1'($urandom_range(0, 1));
         bus.a = pick();
         bus.b = pick();
         case ($urandom_range(0, 3))
            0: bus.R = 32'h7F800000;
            1: bus.R = 32'h00000000;
            2: bus.R = 32'h7F7FFFFF;
            default: bus.R = $urandom;
         endcase
         bus.R = bus.R ^ (32'($urandom_range(0, 1)) << 31);
         bus.io_flag = $urandom_range(0, 3) != 0;
         bus.dz_flag = $urandom_range(0, 3) != 0;
         bus.of_flag = $urandom_range(0, 3) != 0;
         bus.uf_flag = 1'($urandom_range(0, 1));
         bus.i_flag = 1'($urandom_range(0, 1));
         step();
      end
      arst = 1'b0;
      idle();
      steps(R_DLY + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp_flag_monitor.md
FP_FLAG_MONITOR -- requirements
Module: fp_flag_monitor

Interface
REQ-001 SHALL have parameter R_DLY, default 23: cycles from operand issue to result/flags valid; legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter and of the retired-op counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port arst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  operand issue strobe; a, b, sel sampled when 1.
REQ-006 SHALL have port sel  in  1  operation: 0 multiply, 1 divide.
REQ-007 SHALL have ports a, b  in  32 each  IEEE-754 single operands.
REQ-008 SHALL have port R  in  32  DUT result.
REQ-009 SHALL have ports io_flag, dz_flag, of_flag, uf_flag, i_flag  in  1 each  DUT flags.
REQ-010 SHALL have port clr  in  1  clears counters and sticky bits.
REQ-011 SHALL have port err_pulse  out  1  one-cycle pulse when any check fails on a retiring op.
REQ-012 SHALL have port err_sticky  out  5  per-check sticky fail bits, bit index = check id.
REQ-013 SHALL have port err_cnt  out  5*CNT_W  per-check saturating fail counts; check k at [k*CNT_W +: CNT_W].
REQ-014 SHALL have port op_cnt  out  CNT_W  saturating count of retired ops.

Function
REQ-015 SHALL precompute expected-check enables and expectations from a, b, sel at issue, and push them with a valid bit into an R_DLY-deep delay line; en=0 pushes valid=0.
REQ-016 SHALL evaluate checks only at delay-line exit when valid=1, against R and flags present that cycle.
REQ-017 SHALL classify NaN as exp=8'hFF and mant!=0; zero as bits[30:0]==0; finite as exp!=8'hFF.
REQ-018 Check 0 (div by zero): enabled when sel=1, b zero, a nonzero and not NaN; pass iff dz_flag=1 and R[30:0]=31'h7F800000.
REQ-019 Check 1 (zero dividend): enabled when sel=1, a zero, b nonzero and not NaN; pass iff R[30:0]=0.
REQ-020 Check 2 (invalid): enabled when a or b is NaN; pass iff io_flag=1.
REQ-021 Check 3 (sign): enabled when neither operand is NaN; pass iff R[31]=a[31]^b[31].
REQ-022 Check 4 (mult overflow): enabled when sel=0, both finite and nonzero, 9-bit sum a[30:23]+b[30:23] >= 382; pass iff of_flag=1 and R[30:0]=31'h7F800000.
REQ-023 SHALL, per failing check, set err_sticky[k] and increment err_cnt[k], saturating at all-ones.
REQ-024 SHALL increment op_cnt once per retiring valid op, saturating.
REQ-025 SHALL assert err_pulse the cycle after a retiring op fails any check (registered).
REQ-026 SHALL give clr priority: on clr=1, counters and sticky bits go to 0 and failures retiring that cycle are discarded; delay line unaffected.
REQ-027 SHALL sustain one issue per cycle; back-to-back ops retire in order without loss.

Reset
REQ-028 On arst=1 at a clock edge, SHALL clear all delay-line valid bits, err_cnt, err_sticky, op_cnt, err_pulse to 0; in-flight ops are discarded and never checked.
REQ-029 SHALL check ops issued at or after the first edge with arst=0 only.

Configuration
REQ-030 With macro FPMON_SNAPSHOT_EN defined, SHALL add outputs snap_a, snap_b, snap_R (32 each) and snap_id (3), capturing operands, result, and lowest failing check id of the first failure after reset/clr; held until reset or clr.
REQ-031 Without FPMON_SNAPSHOT_EN, those ports and operand storage in the delay line SHALL be absent; all other behaviour identical.

Verification
REQ-032 R_DLY=23: issue sel=1, a=3F800000, b=00000000; drive dz_flag=1, R=7F800000 at +23 -> no err_pulse, op_cnt=1.
REQ-033 Same stimulus with dz_flag=0 at +23 -> err_pulse at +24, err_sticky=5'b00001, err_cnt[0]=1.
REQ-034 Issue sel=0, a=7F000000, b=7F000000; DUT returns of_flag=0, R=7F7FFFFF -> err_cnt[4]=1, err_sticky[4]=1.
REQ-035 Issue a=7FC00000 with io_flag=1 at exit, then arst mid-flight for a second op -> first passes; second never counted, op_cnt=1 only if reset came after first retired.
REQ-036 CNT_W=4: 20 consecutive sign failures (a=3F800000, b=BF800000, R[31]=0) -> err_cnt[3]=15, no wrap; clr coincident with a failure -> all counters 0 next cycle.
